// File: rtl/imm_fetch_ctrl_if.sv
// Immediate-fetch bus: decode request/result handshake plus byte-wide memory read port.
// Optional: IMM_FETCH_SHIFT_EN adds the shift1 request bit.
interface imm_fetch_ctrl_if;
  logic        start;
  logic        long_imm;
  logic        zero_ext;
  logic [15:0] base_addr;
`ifdef IMM_FETCH_SHIFT_EN
  logic        shift1;
`endif
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [15:0] imm;
  logic        imm_valid;
  logic        imm_ack;
  logic        busy;

  // Fetch controller side
  modport slave (
`ifdef IMM_FETCH_SHIFT_EN
    input  shift1,
`endif
    input  start, long_imm, zero_ext, base_addr, mem_data, imm_ack,
    output mem_addr, mem_rd, imm, imm_valid, busy
  );

  // Decode / memory side
  modport master (
`ifdef IMM_FETCH_SHIFT_EN
    output shift1,
`endif
    output start, long_imm, zero_ext, base_addr, mem_data, imm_ack,
    input  mem_addr, mem_rd, imm, imm_valid, busy
  );
endinterface

// File: rtl/imm_fetch_ctrl.sv
// imm_fetch_ctrl: fetches a 1- or 2-byte immediate over a byte-wide read port
// and returns a 16-bit operand on a valid/ack handshake.
// Optional feature macro: IMM_FETCH_SHIFT_EN (short immediates scaled by 2).
module imm_fetch_ctrl #(
  parameter int MEM_LAT = 1   // read latency in cycles, 1..3
) (
  input  logic       clk,
  input  logic       reset,
  imm_fetch_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_LO   = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_RD_HI   = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Wait states leave when the counter reaches zero, so load latency-1.
  localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

  logic [2:0]  r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_base;
  logic        r_long;
  logic        r_zext;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic [15:0] r_imm;
  logic        r_imm_valid;
  logic        r_busy;
`ifdef IMM_FETCH_SHIFT_EN
  logic        r_shift;
`endif

  logic [15:0] w_ext;
  logic [15:0] w_short;

  // Short-immediate result formed straight from the arriving byte
  always_comb begin
    w_ext = r_zext ? {8'h00, bus.mem_data} : {{8{bus.mem_data[7]}}, bus.mem_data};
`ifdef IMM_FETCH_SHIFT_EN
    w_short = r_shift ? {w_ext[14:0], 1'b0} : w_ext;
`else
    w_short = w_ext;
`endif
  end

  // Fetch sequencer; all outputs are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_long      <= 1'b0;
      r_zext      <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_imm       <= '0;
      r_imm_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef IMM_FETCH_SHIFT_EN
      r_shift     <= 1'b0;
`endif
    end else begin
      r_mem_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base     <= bus.base_addr;
            r_long     <= bus.long_imm;
            r_zext     <= bus.zero_ext;
`ifdef IMM_FETCH_SHIFT_EN
            r_shift    <= bus.shift1;
`endif
            r_mem_addr <= bus.base_addr;
            r_mem_rd   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          r_cnt   <= CNT_LOAD;
          r_state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (r_cnt == 2'd0) begin
            r_lo <= bus.mem_data;
            if (r_long) begin
              r_mem_addr <= r_base + 16'd1;   // wraps 0xFFFF -> 0x0000
              r_mem_rd   <= 1'b1;
              r_state    <= S_RD_HI;
            end else begin
              r_imm       <= w_short;
              r_imm_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RD_HI: begin
          r_cnt   <= CNT_LOAD;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (r_cnt == 2'd0) begin
            r_hi    <= bus.mem_data;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_DONE: begin
          // Long results enter DONE unpublished and spend one cycle assembling.
          if (!r_imm_valid) begin
            r_imm       <= {r_hi, r_lo};
            r_imm_valid <= 1'b1;
          end else if (bus.imm_ack) begin
            r_imm_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.imm       = r_imm;
  assign bus.imm_valid = r_imm_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_imm_fetch_ctrl.sv
// Directed bench for imm_fetch_ctrl: one DUT at MEM_LAT=1, one at MEM_LAT=3,
// selected by sel; each has its own latency-accurate memory model.
// Optional feature macro: IMM_FETCH_SHIFT_EN.
module tb_imm_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        start = 1'b0, long_imm = 1'b0, zero_ext = 1'b0, imm_ack = 1'b0;
  logic [15:0] base_addr = '0;
`ifdef IMM_FETCH_SHIFT_EN
  logic        shift1 = 1'b0;
`endif
  logic [15:0] ta0 = '0, ta1 = '0;
  logic [7:0]  td0 = '0, td1 = '0;
  int nrun = 0, nfail = 0;

  imm_fetch_ctrl_if if1();
  imm_fetch_ctrl_if if3();

  imm_fetch_ctrl #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  imm_fetch_ctrl #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  assign if1.start     = start & ~sel;
  assign if3.start     = start & sel;
  assign if1.imm_ack   = imm_ack & ~sel;
  assign if3.imm_ack   = imm_ack & sel;
  assign if1.long_imm  = long_imm;
  assign if3.long_imm  = long_imm;
  assign if1.zero_ext  = zero_ext;
  assign if3.zero_ext  = zero_ext;
  assign if1.base_addr = base_addr;
  assign if3.base_addr = base_addr;
`ifdef IMM_FETCH_SHIFT_EN
  assign if1.shift1 = shift1;
  assign if3.shift1 = shift1;
`endif

  // Memory models: data appears MEM_LAT cycles after the strobe, 0xEE otherwise
  logic [15:0] m1_q;
  logic        v1_q = 1'b0;
  logic [15:0] m3_q [0:2];
  logic [2:0]  v3_q = '0;
  always @(posedge clk) begin
    m1_q  <= if1.mem_addr;
    v1_q  <= if1.mem_rd;
    m3_q[0] <= if3.mem_addr;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
    v3_q  <= {v3_q[1:0], if3.mem_rd};
  end
  assign if1.mem_data = !v1_q ? 8'hEE : (m1_q == ta0) ? td0 : (m1_q == ta1) ? td1 : 8'hEE;
  assign if3.mem_data = !v3_q[2] ? 8'hEE : (m3_q[2] == ta0) ? td0 : (m3_q[2] == ta1) ? td1 : 8'hEE;

  logic [15:0] o_imm, o_addr;
  logic        o_valid, o_busy, o_rd;
  assign o_imm   = sel ? if3.imm       : if1.imm;
  assign o_addr  = sel ? if3.mem_addr  : if1.mem_addr;
  assign o_valid = sel ? if3.imm_valid : if1.imm_valid;
  assign o_busy  = sel ? if3.busy      : if1.busy;
  assign o_rd    = sel ? if3.mem_rd    : if1.mem_rd;

  // Read-strobe monitor on the selected DUT
  int          rd_cnt = 0;
  logic [15:0] la = '0, pa = '0;
  always @(posedge clk) if (o_rd) begin
    rd_cnt <= rd_cnt + 1;
    pa <= la;
    la <= o_addr;
  end

  task automatic fetch(input logic lng, input logic zx, input logic [15:0] base, output int lat);
    @(negedge clk); start = 1'b1; long_imm = lng; zero_ext = zx; base_addr = base;
    @(negedge clk); start = 1'b0; long_imm = ~lng; zero_ext = ~zx; base_addr = ~base;
`ifdef IMM_FETCH_SHIFT_EN
    shift1 = ~shift1;
`endif
    lat = 1;
    while (o_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (o_valid !== 1'b1) lat = -1;
  endtask

  task automatic ack();
    imm_ack = 1'b1; @(negedge clk); imm_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    nrun++; if ({if1.mem_addr, if1.mem_rd, if1.imm, if1.imm_valid, if1.busy} !== 35'd0) begin nfail++;
      $display("FAIL reset_dut1 got %h want 0", {if1.mem_addr, if1.mem_rd, if1.imm, if1.imm_valid, if1.busy}); end
    nrun++; if ({if3.mem_addr, if3.mem_rd, if3.imm, if3.imm_valid, if3.busy} !== 35'd0) begin nfail++;
      $display("FAIL reset_dut3 got %h want 0", {if3.mem_addr, if3.mem_rd, if3.imm, if3.imm_valid, if3.busy}); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_short();
    int lat, c0;
    sel = 1'b0; ta0 = 16'h0040; td0 = 8'h85; c0 = rd_cnt;
    fetch(1'b0, 1'b0, 16'h0040, lat);
    nrun++; if (lat !== 3) begin nfail++; $display("FAIL short_lat got %0d want 3", lat); end
    nrun++; if (o_imm !== 16'hFF85) begin nfail++; $display("FAIL short_sx got %h want ff85", o_imm); end
    nrun++; if (rd_cnt - c0 !== 1 || la !== 16'h0040) begin nfail++;
      $display("FAIL short_rd got n=%0d a=%h want n=1 a=0040", rd_cnt - c0, la); end
    nrun++; if (o_busy !== 1'b1) begin nfail++; $display("FAIL short_busy got %b want 1", o_busy); end
    ack();
    nrun++; if ({o_valid, o_busy, o_imm} !== {2'b00, 16'hFF85}) begin nfail++;
      $display("FAIL short_after_ack got v=%b b=%b imm=%h want 0 0 ff85", o_valid, o_busy, o_imm); end
    td0 = 8'h7F;
    fetch(1'b0, 1'b0, 16'h0040, lat); ack();
    nrun++; if (o_imm !== 16'h007F) begin nfail++; $display("FAIL short_pos got %h want 007f", o_imm); end
    td0 = 8'h85;
    fetch(1'b0, 1'b1, 16'h0040, lat); ack();
    nrun++; if (o_imm !== 16'h0085) begin nfail++; $display("FAIL short_zx got %h want 0085", o_imm); end
  endtask

  task automatic test_long();
    int lat, c0;
    sel = 1'b0; ta0 = 16'h1000; td0 = 8'h34; ta1 = 16'h1001; td1 = 8'h12; c0 = rd_cnt;
    fetch(1'b1, 1'b0, 16'h1000, lat);
    nrun++; if (lat !== 6) begin nfail++; $display("FAIL long_lat got %0d want 6", lat); end
    nrun++; if (o_imm !== 16'h1234) begin nfail++; $display("FAIL long_imm got %h want 1234", o_imm); end
    nrun++; if (rd_cnt - c0 !== 2 || pa !== 16'h1000 || la !== 16'h1001) begin nfail++;
      $display("FAIL long_rd got n=%0d %h %h want 2 1000 1001", rd_cnt - c0, pa, la); end
    ack();
    ta0 = 16'hFFFF; td0 = 8'hCD; ta1 = 16'h0000; td1 = 8'hAB;
    fetch(1'b1, 1'b0, 16'hFFFF, lat);
    nrun++; if (o_imm !== 16'hABCD || la !== 16'h0000) begin nfail++;
      $display("FAIL long_wrap got imm=%h a=%h want abcd 0000", o_imm, la); end
    ack();
  endtask

  task automatic test_lat3_hold();
    int lat;
    sel = 1'b1; ta0 = 16'h2000; td0 = 8'h78; ta1 = 16'h2001; td1 = 8'h56;
    @(negedge clk);
    fetch(1'b1, 1'b0, 16'h2000, lat);
    nrun++; if (lat !== 10) begin nfail++; $display("FAIL lat3_lat got %0d want 10", lat); end
    for (int i = 0; i < 5; i++) begin
      nrun++; if ({o_valid, o_busy, o_imm} !== {2'b11, 16'h5678}) begin nfail++;
        $display("FAIL lat3_hold[%0d] got v=%b b=%b imm=%h want 1 1 5678", i, o_valid, o_busy, o_imm); end
      @(negedge clk);
    end
    ack();
    nrun++; if ({o_valid, o_busy} !== 2'b00) begin nfail++;
      $display("FAIL lat3_ack got v=%b b=%b want 0 0", o_valid, o_busy); end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int c0;
    sel = 1'b0; ta0 = 16'h0200; td0 = 8'h11; ta1 = 16'h0300; td1 = 8'h22; c0 = rd_cnt;
    @(negedge clk); start = 1'b1; long_imm = 1'b0; zero_ext = 1'b0; base_addr = 16'h0200;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; base_addr = 16'h0300;        // WAIT_LO
    @(negedge clk);                                           // DONE, start still high
    nrun++; if (o_valid !== 1'b1) begin nfail++; $display("FAIL ign_valid got %b want 1", o_valid); end
    @(negedge clk); start = 1'b0;
    nrun++; if (o_imm !== 16'h0011 || rd_cnt - c0 !== 1) begin nfail++;
      $display("FAIL ign_result got imm=%h n=%0d want 0011 1", o_imm, rd_cnt - c0); end
    ack();
    repeat (4) @(negedge clk);
    nrun++; if ({o_valid, o_busy} !== 2'b00 || rd_cnt - c0 !== 1) begin nfail++;
      $display("FAIL ign_no_second got v=%b b=%b n=%0d want 0 0 1", o_valid, o_busy, rd_cnt - c0); end
  endtask

  task automatic test_reset_mid();
    int lat;
    sel = 1'b0; ta0 = 16'h1000; td0 = 8'h34; ta1 = 16'h1001; td1 = 8'h12;
    @(negedge clk); start = 1'b1; long_imm = 1'b1; base_addr = 16'h1000;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);                                // c4: WAIT_HI
    nrun++; if (o_busy !== 1'b1) begin nfail++; $display("FAIL mid_busy got %b want 1", o_busy); end
    reset = 1'b1; #1;
    nrun++; if ({o_addr, o_rd, o_imm, o_valid, o_busy} !== 35'd0) begin nfail++;
      $display("FAIL mid_reset got %h want 0", {o_addr, o_rd, o_imm, o_valid, o_busy}); end
    @(negedge clk); reset = 1'b0;
    fetch(1'b1, 1'b0, 16'h1000, lat);
    nrun++; if (lat !== 6 || o_imm !== 16'h1234) begin nfail++;
      $display("FAIL mid_refetch got lat=%0d imm=%h want 6 1234", lat, o_imm); end
    ack();
  endtask

`ifdef IMM_FETCH_SHIFT_EN
  task automatic test_shift();
    int lat;
    sel = 1'b0; ta0 = 16'h0500; td0 = 8'hC1;
    shift1 = 1'b1; fetch(1'b0, 1'b0, 16'h0500, lat); ack();
    nrun++; if (o_imm !== 16'hFF82) begin nfail++; $display("FAIL shift_short got %h want ff82", o_imm); end
    ta0 = 16'h1000; td0 = 8'h34; ta1 = 16'h1001; td1 = 8'h12;
    shift1 = 1'b1; fetch(1'b1, 1'b0, 16'h1000, lat); ack();
    nrun++; if (o_imm !== 16'h1234) begin nfail++; $display("FAIL shift_long got %h want 1234", o_imm); end
  endtask
`endif

  initial begin
    test_reset();
    test_short();
    test_long();
    test_lat3_hold();
    test_ignore_start();
    test_reset_mid();
`ifdef IMM_FETCH_SHIFT_EN
    test_shift();
`endif
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
